seq_fixed_div: RTL and testbench
================================

// Module: seq_fixed_div
// PURPOSE
//  Iterative signed fixed-point divider: out = a / b. Same Q(INT_BITS).(FRAC_BITS) format as the pipelined multiplier.
//  Radix-2 restoring division on magnitudes, one quotient bit per clock, with valid/ready handshake on both sides.
//  Feeds fractal iteration and colour stages that need reciprocals/ratios; one operation in flight.
// PARAMETERS
//  INT_BITS   1   integer bits incl. sign
//  FRAC_BITS  17  fractional bits; NUM_BITS = INT_BITS+FRAC_BITS (localparam)
// PORTS
//  clock        in   1         single clock, rising edge
//  reset        in   1         asynchronous, active-high
//  in_valid     in   1         a/b valid
//  in_ready     out  1         divider idle, can accept
//  a            in   NUM_BITS  signed dividend
//  b            in   NUM_BITS  signed divisor
//  out_valid    out  1         result valid, held until out_ready
//  out_ready    in   1         consumer accepts result
//  out          out  NUM_BITS  signed quotient
//  div_by_zero  out  1         b was 0 (valid with out_valid)
//  overflow     out  1         |quotient| not representable, saturated (valid with out_valid)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out=0, flags=0. Reset mid-operation aborts it; no result is emitted.
//  FSM: IDLE -(in_valid&in_ready)-> CALC -(counter==last)-> DONE -(out_ready)-> IDLE.
//  in_ready = (state==IDLE). No accept in CALC/DONE. DONE->IDLE edge does not accept; in_ready rises the next cycle.
//  Accept edge: latch sign = a[MSB]^b[MSB]. Latch |a| and |b| as NUM_BITS-wide unsigned (|MIN| = 2^(NUM_BITS-1) fits).
//  Latch flags: div_by_zero = (b==0); overflow = (b!=0) && (|a| >= |b| << (INT_BITS-1)).
//  CALC: NUM_BITS-1 cycles, each one restoring step: rem = {rem,next dividend bit}; if rem>=|b| then subtract, q bit=1.
//  Dividend = |a| << FRAC_BITS. Quotient magnitude is NUM_BITS-1 bits. Truncation toward zero.
//  Fixed latency: out_valid rises NUM_BITS-1 edges after the accept edge, regardless of operands (special cases included).
//  Result at DONE entry: div_by_zero -> a<0 ? MIN : MAX. Else overflow -> sign ? MIN : MAX. Else sign ? -q : q.
//  MAX = 2^(NUM_BITS-1)-1, MIN = -2^(NUM_BITS-1). An exact result of MIN is flagged overflow; out = MIN, which is correct.
//  a==0, b!=0 -> out=0, no flags. a==0, b==0 -> MAX, div_by_zero=1.
//  out and flags are stable while out_valid=1 && out_ready=0. out_valid drops on the edge where out_ready=1.
//  Throughput: one result per NUM_BITS+1 cycles with out_ready held high.
// CONFIGURATION
//  SEQ_DIV_ROUND_EN defined:
//   - One extra CALC step computes a guard bit. Latency is NUM_BITS edges.
//   - Round half away from zero on the magnitude before negation.
//   - If rounding carries the magnitude past MAX (positive) or 2^(NUM_BITS-1) (negative), saturate and set overflow.
//  SEQ_DIV_ROUND_EN undefined: truncate toward zero, latency NUM_BITS-1 edges.
// STRUCTURE
//  Package fractal_fixed_pkg holds:
//   - NUM_BITS-derived constants FIX_MAX and FIX_MIN.
//   - typedef fixed_t (signed [NUM_BITS-1:0]).
//   - typedef div_state_t {IDLE, CALC, DONE}.
//  Sub-module div_step: combinational single restoring step (rem_in, divisor, dividend bit -> rem_out, q_bit).
//  The top level holds the FSM, counter, magnitude/sign/flag logic and result registers.
// TESTING (Q1.17, 18-bit hex)
//  a=0x08000 (0.25), b=0x10000 (0.5) -> out=0x10000 (0.5), flags 0, out_valid exactly 17 edges after accept (18 with round).
//  a=0x38000 (-0.25), b=0x10000 -> out=0x30000 (-0.5); a=0x38000, b=0x30000 -> out=0x10000.
//  a=0x10000, b=0x08000 (quotient 2.0) -> out=0x1FFFF, overflow=1. a=0x10000, b=0x38000 -> out=0x20000, overflow=1.
//  a=0x38000, b=0 -> out=0x20000, div_by_zero=1. a=0, b=0 -> out=0x1FFFF, div_by_zero=1.
//  a=0x00001, b=0x0C000 (0.375) -> out=0x00002 without SEQ_DIV_ROUND_EN, 0x00003 with it.
//  Backpressure and reset:
//   - Hold out_ready=0 for 5 cycles: out stable, in_ready=0, new in_valid ignored.
//   - Assert reset mid-CALC: out_valid stays 0, in_ready=1 after release, next op correct.

Source files
------------

// File: rtl/seq_fixed_div_pkg.sv
// Shared fixed-point constants and types for the fractal datapath (default Q1.17).
package fractal_fixed_pkg;

    localparam int FIX_INT_BITS  = 1;
    localparam int FIX_FRAC_BITS = 17;
    localparam int FIX_NUM_BITS  = FIX_INT_BITS + FIX_FRAC_BITS;

    typedef logic signed [FIX_NUM_BITS-1:0] fixed_t;

    localparam fixed_t FIX_MAX = {1'b0, {(FIX_NUM_BITS-1){1'b1}}};
    localparam fixed_t FIX_MIN = {1'b1, {(FIX_NUM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_fixed_div_if.sv
// Operand/result handshake bundle for seq_fixed_div; master = producer/consumer side, slave = divider.
interface seq_fixed_div_if
    import fractal_fixed_pkg::*;
#(
    parameter int NUM_BITS = FIX_NUM_BITS
);

    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] out;
    logic                div_by_zero;
    logic                overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, div_by_zero, overflow
    );

endinterface

// File: rtl/seq_fixed_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
    parameter int W = 18
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] divisor_i,
    input  logic         dvd_bit_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0] trial_s;

    // Trial subtraction on the shifted partial remainder
    always_comb begin
        trial_s = {rem_i, dvd_bit_i};
        if (trial_s >= {1'b0, divisor_i}) begin
            q_bit_o = 1'b1;
            rem_o   = W'(trial_s - {1'b0, divisor_i});
        end else begin
            q_bit_o = 1'b0;
            rem_o   = trial_s[W-1:0];
        end
    end

endmodule

// File: rtl/seq_fixed_div.sv
// Iterative signed fixed-point divider out = a / b, one quotient bit per clock.
// Define SEQ_DIV_ROUND_EN for a guard-bit step with round-half-away-from-zero (else truncate).
module seq_fixed_div
    import fractal_fixed_pkg::*;
#(
    parameter int INT_BITS  = FIX_INT_BITS,
    parameter int FRAC_BITS = FIX_FRAC_BITS
) (
    input  logic          clock,
    input  logic          reset,
    seq_fixed_div_if.slave bus
);

    localparam int NUM_BITS = INT_BITS + FRAC_BITS;
`ifdef SEQ_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int STEPS = NUM_BITS - 1 + RND;
    localparam int CW    = $clog2(STEPS);
    localparam int OW    = NUM_BITS + INT_BITS - 1;
    localparam logic [NUM_BITS-1:0] MAX_C  = {1'b0, {(NUM_BITS-1){1'b1}}};
    localparam logic [NUM_BITS-1:0] MIN_C  = {1'b1, {(NUM_BITS-1){1'b0}}};
    localparam logic [CW-1:0]       LAST_C = CW'(STEPS - 1);

    div_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_BITS-1:0] rem_q, rem_d, divisor_q, divisor_d;
    logic [STEPS-1:0]    dvd_q, dvd_d;
    logic [STEPS-2:0]    quo_q, quo_d;
    logic                sign_q, sign_d, a_neg_q, a_neg_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [NUM_BITS-1:0] res_q, res_d;
    logic                res_dbz_q, res_dbz_d, res_ovf_q, res_ovf_d;

    logic [NUM_BITS-1:0] mag_a_s, mag_b_s, step_rem_s, mag_q_s;
    logic [STEPS-1:0]    quo_fin_s;
    logic                step_q_s, round_ovf_s;

    div_step #(.W(NUM_BITS)) u_step (
        .rem_i     (rem_q),
        .divisor_i (divisor_q),
        .dvd_bit_i (dvd_q[STEPS-1]),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_q_s)
    );

    // Operand magnitudes; |MIN| = 2^(NUM_BITS-1) is exact as unsigned
    always_comb begin
        mag_a_s = bus.a[NUM_BITS-1] ? ((~bus.a) + NUM_BITS'(1)) : bus.a;
        mag_b_s = bus.b[NUM_BITS-1] ? ((~bus.b) + NUM_BITS'(1)) : bus.b;
    end

    // Final quotient magnitude, with optional guard-bit rounding
    always_comb begin
        quo_fin_s = {quo_q, step_q_s};
`ifdef SEQ_DIV_ROUND_EN
        mag_q_s     = NUM_BITS'(quo_fin_s[STEPS-1:1]) + NUM_BITS'(quo_fin_s[0]);
        round_ovf_s = sign_q ? (mag_q_s > MIN_C) : (mag_q_s > MAX_C);
`else
        mag_q_s     = NUM_BITS'(quo_fin_s);
        round_ovf_s = 1'b0;
`endif
    end

    // FSM next state and iteration datapath
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        sign_d    = sign_q;
        a_neg_d   = a_neg_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d   = CALC;
                    cnt_d     = {CW{1'b0}};
                    // Leading quotient bits are zero whenever no overflow, so start part-way in
                    rem_d     = mag_a_s >> (INT_BITS - 1);
                    dvd_d     = STEPS'({mag_a_s, {(FRAC_BITS + RND){1'b0}}});
                    quo_d     = {(STEPS-1){1'b0}};
                    divisor_d = mag_b_s;
                    sign_d    = bus.a[NUM_BITS-1] ^ bus.b[NUM_BITS-1];
                    a_neg_d   = bus.a[NUM_BITS-1];
                    dbz_d     = (bus.b == {NUM_BITS{1'b0}});
                    ovf_d     = (bus.b != {NUM_BITS{1'b0}}) &&
                                (OW'(mag_a_s) >= (OW'(mag_b_s) << (INT_BITS - 1)));
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = step_rem_s;
                dvd_d = {dvd_q[STEPS-2:0], 1'b0};
                quo_d = quo_fin_s[STEPS-2:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_C) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result selection, captured on the last CALC edge
    always_comb begin
        res_d     = res_q;
        res_dbz_d = res_dbz_q;
        res_ovf_d = res_ovf_q;
        if ((state_q == CALC) && (cnt_q == LAST_C)) begin
            res_dbz_d = dbz_q;
            res_ovf_d = ~dbz_q & (ovf_q | round_ovf_s);
            if (dbz_q) begin
                res_d = a_neg_q ? MIN_C : MAX_C;
            end else if (ovf_q || round_ovf_s) begin
                res_d = sign_q ? MIN_C : MAX_C;
            end else if (sign_q) begin
                res_d = (~mag_q_s) + NUM_BITS'(1);
            end else begin
                res_d = mag_q_s;
            end
        end else begin
            res_d = res_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            rem_q     <= {NUM_BITS{1'b0}};
            divisor_q <= {NUM_BITS{1'b0}};
            dvd_q     <= {STEPS{1'b0}};
            quo_q     <= {(STEPS-1){1'b0}};
            sign_q    <= 1'b0;
            a_neg_q   <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            res_q     <= {NUM_BITS{1'b0}};
            res_dbz_q <= 1'b0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            sign_q    <= sign_d;
            a_neg_q   <= a_neg_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_dbz_q <= res_dbz_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out         = res_q;
    assign bus.div_by_zero = res_dbz_q;
    assign bus.overflow    = res_ovf_q;

endmodule

// File: tb/tb_seq_fixed_div.sv
// Directed self-checking bench for seq_fixed_div in Q1.17 (honours SEQ_DIV_ROUND_EN).
module tb_seq_fixed_div;
    import fractal_fixed_pkg::*;

`ifdef SEQ_DIV_ROUND_EN
    localparam int EXP_LAT = 18;
`else
    localparam int EXP_LAT = 17;
`endif

    logic clock;
    logic reset;
    int   pass_cnt;
    int   chk_cnt;

    seq_fixed_div_if #(.NUM_BITS(18)) dif ();

    seq_fixed_div dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic run_op(input logic [17:0] av, input logic [17:0] bv,
                          output fixed_t res, output logic dz, output logic ov, output int lat);
        dif.a        = av;
        dif.b        = bv;
        dif.in_valid = 1'b1;
        @(posedge clock);
        #1;
        dif.in_valid = 1'b0;
        lat = 0;
        while (!dif.out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        res = dif.out;
        dz  = dif.div_by_zero;
        ov  = dif.overflow;
        dif.out_ready = 1'b1;
        @(posedge clock);
        #1;
        dif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        chk_cnt++; if (dif.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", dif.in_ready); else pass_cnt++;
        chk_cnt++; if (dif.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", dif.out_valid); else pass_cnt++;
        chk_cnt++; if (dif.out !== 18'h00000) $display("FAIL rst_out: got %h expected 00000", dif.out); else pass_cnt++;
        chk_cnt++; if (dif.div_by_zero !== 1'b0) $display("FAIL rst_dbz: got %b expected 0", dif.div_by_zero); else pass_cnt++;
        chk_cnt++; if (dif.overflow !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", dif.overflow); else pass_cnt++;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_cnt++; if (dif.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", dif.in_ready); else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [17:0] va [12];
        logic [17:0] vb [12];
        logic [17:0] vo [12];
        logic        vd [12];
        logic        vv [12];
        fixed_t      res;
        logic        dz, ov;
        int          lat;
        va = '{18'h08000, 18'h38000, 18'h38000, 18'h10000, 18'h10000, 18'h38000,
               18'h00000, 18'h00001, 18'h3FFFF, 18'h00000, 18'h30000, 18'h20000};
        vb = '{18'h10000, 18'h10000, 18'h30000, 18'h08000, 18'h38000, 18'h00000,
               18'h00000, 18'h0C000, 18'h0C000, 18'h10000, 18'h10000, 18'h20000};
`ifdef SEQ_DIV_ROUND_EN
        vo = '{18'h10000, 18'h30000, 18'h10000, 18'h1FFFF, 18'h20000, 18'h20000,
               18'h1FFFF, 18'h00003, 18'h3FFFD, 18'h00000, 18'h20000, 18'h1FFFF};
`else
        vo = '{18'h10000, 18'h30000, 18'h10000, 18'h1FFFF, 18'h20000, 18'h20000,
               18'h1FFFF, 18'h00002, 18'h3FFFE, 18'h00000, 18'h20000, 18'h1FFFF};
`endif
        vd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            run_op(va[i], vb[i], res, dz, ov, lat);
            chk_cnt++; if (res !== vo[i]) $display("FAIL vec%0d_out: got %h expected %h", i, res, vo[i]); else pass_cnt++;
            chk_cnt++; if (dz !== vd[i]) $display("FAIL vec%0d_dbz: got %b expected %b", i, dz, vd[i]); else pass_cnt++;
            chk_cnt++; if (ov !== vv[i]) $display("FAIL vec%0d_ovf: got %b expected %b", i, ov, vv[i]); else pass_cnt++;
            chk_cnt++; if (lat != EXP_LAT) $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, EXP_LAT); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int wait_cnt;
        dif.a        = 18'h08000;
        dif.b        = 18'h10000;
        dif.in_valid = 1'b1;
        @(posedge clock);
        #1;
        dif.in_valid = 1'b0;
        wait_cnt = 0;
        while (!dif.out_valid && wait_cnt < 200) begin
            @(posedge clock);
            #1;
            wait_cnt++;
        end
        chk_cnt++; if (dif.out_valid !== 1'b1) $display("FAIL bp_wait: got out_valid %b expected 1", dif.out_valid); else pass_cnt++;
        dif.a        = 18'h10000;
        dif.b        = 18'h08000;
        dif.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk_cnt++; if (dif.out !== 18'h10000) $display("FAIL bp_out_c%0d: got %h expected 10000", c, dif.out); else pass_cnt++;
            chk_cnt++; if (dif.out_valid !== 1'b1) $display("FAIL bp_valid_c%0d: got %b expected 1", c, dif.out_valid); else pass_cnt++;
            chk_cnt++; if (dif.in_ready !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, dif.in_ready); else pass_cnt++;
            chk_cnt++; if (dif.overflow !== 1'b0) $display("FAIL bp_ovf_c%0d: got %b expected 0", c, dif.overflow); else pass_cnt++;
        end
        dif.out_ready = 1'b1;
        @(posedge clock);
        #1;
        dif.out_ready = 1'b0;
        chk_cnt++; if (dif.out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", dif.out_valid); else pass_cnt++;
        chk_cnt++; if (dif.in_ready !== 1'b1) $display("FAIL bp_no_accept_on_release: got %b expected 1", dif.in_ready); else pass_cnt++;
        dif.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int     k1, k2;
        fixed_t r1, r2;
        k1 = -1;
        k2 = -1;
        r1 = 18'h00000;
        r2 = 18'h00000;
        dif.a         = 18'h38000;
        dif.b         = 18'h10000;
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        for (int i = 0; i < 100 && k2 < 0; i++) begin
            @(posedge clock);
            #1;
            if (dif.out_valid) begin
                if (k1 < 0) begin
                    k1 = i;
                    r1 = dif.out;
                end else begin
                    k2 = i;
                    r2 = dif.out;
                    dif.in_valid = 1'b0;
                end
            end
        end
        dif.in_valid = 1'b0;
        @(posedge clock);
        #1;
        dif.out_ready = 1'b0;
        chk_cnt++; if (k2 < 0 || (k2 - k1) != EXP_LAT + 2) $display("FAIL b2b_period: got %0d expected %0d", k2 - k1, EXP_LAT + 2); else pass_cnt++;
        chk_cnt++; if (r1 !== 18'h30000) $display("FAIL b2b_out1: got %h expected 30000", r1); else pass_cnt++;
        chk_cnt++; if (r2 !== 18'h30000) $display("FAIL b2b_out2: got %h expected 30000", r2); else pass_cnt++;
        chk_cnt++; if (dif.in_ready !== 1'b1) $display("FAIL b2b_idle: got %b expected 1", dif.in_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        logic   seen;
        fixed_t res;
        logic   dz, ov;
        int     lat;
        dif.a        = 18'h10000;
        dif.b        = 18'h08000;
        dif.in_valid = 1'b1;
        @(posedge clock);
        #1;
        dif.in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #2;
        chk_cnt++; if (dif.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b expected 1", dif.in_ready); else pass_cnt++;
        chk_cnt++; if (dif.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b expected 0", dif.out_valid); else pass_cnt++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (dif.out_valid) seen = 1'b1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL mid_rst_no_result: got %b expected 0", seen); else pass_cnt++;
        chk_cnt++; if (dif.in_ready !== 1'b1) $display("FAIL mid_rst_ready_after: got %b expected 1", dif.in_ready); else pass_cnt++;
        run_op(18'h38000, 18'h30000, res, dz, ov, lat);
        chk_cnt++; if (res !== 18'h10000) $display("FAIL mid_rst_next_out: got %h expected 10000", res); else pass_cnt++;
        chk_cnt++; if (ov !== 1'b0 || dz !== 1'b0) $display("FAIL mid_rst_next_flags: got %b%b expected 00", dz, ov); else pass_cnt++;
        chk_cnt++; if (lat != EXP_LAT) $display("FAIL mid_rst_next_latency: got %0d expected %0d", lat, EXP_LAT); else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        chk_cnt       = 0;
        reset         = 1'b1;
        dif.in_valid  = 1'b0;
        dif.a         = 18'h00000;
        dif.b         = 18'h00000;
        dif.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
